// File: rtl/ct_stream_ctrl_pkg.sv
// Shared types and size helpers for the ciphertext read-out controller.
// The beat count and address width are derived from the memory geometry.
`ifndef CLOG2
`define CLOG2(x) (((x) <= 1) ? 0 : $clog2(x))
`endif

package ct_stream_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SEND  = 3'd3,
        FIN   = 3'd4
    } state_t;

    function automatic int calc_beats(input int width, input int out_w);
        return (width + out_w - 1) / out_w;
    endfunction

    // Counter widths never drop below one bit, even for single-entry ranges.
    function automatic int calc_cnt_w(input int range);
        return (`CLOG2(range) < 1) ? 1 : `CLOG2(range);
    endfunction

endpackage

// File: rtl/ct_stream_ctrl_if.sv
// Control, memory-port and output-stream signals of the read-out controller.
// master = controller side, slave = environment (memory, sink, sequencer).
interface ct_stream_ctrl_if
    import ct_stream_ctrl_pkg::*;
#(
    parameter int WIDTH = 86,
    parameter int DEPTH = 3,
    parameter int OUT_W = 32
);
    localparam int AW = calc_cnt_w(DEPTH);

    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic [AW-1:0]    mem_addr;
    logic             mem_rw;
    logic [WIDTH-1:0] mem_din;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        input  start, abort, mem_din, out_ready,
        output busy, done, mem_addr, mem_rw, out_data, out_valid, out_last
    );

    modport slave (
        output start, abort, mem_din, out_ready,
        input  busy, done, mem_addr, mem_rw, out_data, out_valid, out_last
    );
endinterface

// File: rtl/ct_stream_ctrl.sv
// Walks the ciphertext memory from address 0 upwards and streams each word
// as OUT_W-bit beats; drives the shared address bus only while fetching.
module ct_stream_ctrl
    import ct_stream_ctrl_pkg::*;
#(
    parameter int WIDTH = 86,
    parameter int DEPTH = 3,
    parameter int OUT_W = 32
)(
    input  logic              clk,
    input  logic              rst_b,
    ct_stream_ctrl_if.master  bus
);
    localparam int BEATS = calc_beats(WIDTH, OUT_W);
    localparam int AW    = calc_cnt_w(DEPTH);
    localparam int BW    = calc_cnt_w(BEATS);
    localparam int PAD_W = BEATS * OUT_W;

    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    state_t           state_reg, state_next;
    logic [AW-1:0]    word_cnt_reg, word_cnt_next;
    logic [BW-1:0]    beat_cnt_reg, beat_cnt_next;
    logic [PAD_W-1:0] buf_reg, buf_next;
    logic [AW-1:0]    mem_addr_reg, mem_addr_next;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_reg    <= IDLE;
            word_cnt_reg <= '0;
            beat_cnt_reg <= '0;
            buf_reg      <= '0;
            mem_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            word_cnt_reg <= word_cnt_next;
            beat_cnt_reg <= beat_cnt_next;
            buf_reg      <= buf_next;
            mem_addr_reg <= mem_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg;
        beat_cnt_next = beat_cnt_reg;
        buf_next      = buf_reg;
        mem_addr_next = '0;

        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next    = FETCH;
                    word_cnt_next = '0;
                end
            end
            FETCH: state_next = WAIT;
            WAIT: begin
                // Zero padding above WIDTH keeps the final beat's upper bits clear.
                buf_next               = '0;
                buf_next[WIDTH-1:0]    = bus.mem_din;
                beat_cnt_next          = '0;
                state_next             = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (beat_cnt_reg != LAST_BEAT) begin
                        beat_cnt_next = beat_cnt_reg + BW'(1);
                    end else if (word_cnt_reg != LAST_WORD) begin
                        word_cnt_next = word_cnt_reg + AW'(1);
                        state_next    = FETCH;
                    end else begin
                        state_next    = FIN;
                    end
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Abort overrides everything, including a handshake in the same cycle.
        if (bus.abort) begin
            state_next    = IDLE;
            word_cnt_next = '0;
            beat_cnt_next = '0;
        end

        // Registered address: presented exactly during the FETCH cycle.
        if (state_next == FETCH) begin
            mem_addr_next = word_cnt_next;
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == FIN);
    assign bus.out_valid = (state_reg == SEND);
    assign bus.out_last  = (state_reg == SEND) && (word_cnt_reg == LAST_WORD)
                           && (beat_cnt_reg == LAST_BEAT);
    assign bus.out_data  = (state_reg == SEND)
                           ? buf_reg[int'(beat_cnt_reg) * OUT_W +: OUT_W]
                           : '0;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_rw    = 1'b0;

endmodule

// File: tb/tb_ct_stream_ctrl.sv
// Bench for ct_stream_ctrl: a 3-word x 86-bit instance driven from a vector
// table with a beat scoreboard, plus a single-word 32-bit instance.
module tb_ct_stream_ctrl;
    import ct_stream_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    ct_stream_ctrl_if #(.WIDTH(86), .DEPTH(3), .OUT_W(32)) s1 ();
    ct_stream_ctrl_if #(.WIDTH(32), .DEPTH(1), .OUT_W(32)) s2 ();

    ct_stream_ctrl #(.WIDTH(86), .DEPTH(3), .OUT_W(32)) dut1 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (s1)
    );

    ct_stream_ctrl #(.WIDTH(32), .DEPTH(1), .OUT_W(32)) dut2 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (s2)
    );

    // Registered-read memory models: data valid one cycle after the address.
    logic [85:0] mem [4];
    logic [31:0] mem2;
    always_ff @(posedge clk) begin
        s1.mem_din <= mem[s1.mem_addr];
        s2.mem_din <= mem2;
    end

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;
    beat_t sb[$];

    typedef struct {
        logic [3:0] ready_pat;
        bit         rand_data;
        bit         repulse;
        int         abort_cycle;
        int         done_cyc;
        int         fc1;
        int         fc2;
    } vec_t;
    vec_t vecs[6];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          t;
        int          last_t;
        logic        stall;
        logic [31:0] st_data;
        logic        st_last;
        logic [1:0]  exp_addr;
        logic        exp_busy;
        logic [95:0] r96;
        logic [87:0] r88;
        beat_t       e;

        for (int k = 0; k < 3; k++) begin
            if (v.rand_data) begin
                r96 = {$urandom, $urandom, $urandom};
                mem[k] = r96[85:0];
            end else begin
                r88 = {11{8'(k + 1)}};
                mem[k] = r88[85:0];
            end
        end
        mem[3] = '0;
        sb.delete();
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 3; b++) begin
                e.data = (b == 2) ? {10'b0, mem[w][85:64]} : mem[w][32*b +: 32];
                e.last = (w == 2) && (b == 2);
                sb.push_back(e);
            end
        end

        @(posedge clk); #1;
        s1.start     = 1'b1;
        s1.abort     = 1'b0;
        s1.out_ready = v.ready_pat[0];
        t       = 0;
        stall   = 1'b0;
        st_data = '0;
        st_last = 1'b0;
        last_t  = (v.abort_cycle >= 0) ? v.abort_cycle + 3 : v.done_cyc + 1;
        while (t <= last_t) begin
            @(negedge clk);
            if (v.abort_cycle >= 0 && t > v.abort_cycle) begin
                check("post_abort", 128'({s1.busy, s1.done, s1.out_valid, s1.out_last, s1.mem_addr}), 128'(0));
                stall = 1'b0;
            end else begin
                exp_busy = (t >= 1) && (v.abort_cycle >= 0 || t <= v.done_cyc);
                check("busy_done", 128'({s1.busy, s1.done}), 128'({exp_busy, t == v.done_cyc}));
                exp_addr = (t == v.fc1) ? 2'd1 : (t == v.fc2) ? 2'd2 : 2'd0;
                check("mem_bus", 128'({s1.mem_rw, s1.mem_addr}), 128'({1'b0, exp_addr}));
                if (stall) begin
                    check("stall_hold", 128'({s1.out_valid, s1.out_last, s1.out_data}),
                          128'({1'b1, st_last, st_data}));
                end
                if (s1.out_valid && s1.out_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_beat: got data %0h with scoreboard empty, expected no beat", s1.out_data);
                    end else begin
                        e = sb.pop_front();
                        check("beat", 128'({s1.out_last, s1.out_data}), 128'({e.last, e.data}));
                    end
                end
                stall   = s1.out_valid && !s1.out_ready;
                st_data = s1.out_data;
                st_last = s1.out_last;
            end
            @(posedge clk); #1;
            t++;
            s1.start     = v.repulse && (t == 5 || t == 12);
            s1.abort     = (t == v.abort_cycle);
            s1.out_ready = v.ready_pat[t % 4];
        end
        s1.start = 1'b0;
        s1.abort = 1'b0;
        if (v.abort_cycle >= 0) begin
            sb.delete();
        end else begin
            check("beats_left", 128'(sb.size()), 128'(0));
        end
        $display("[TB] vector %0d: ready_pat=%b abort_cycle=%0d repulse=%0d done_cycle=%0d",
                 idx, v.ready_pat, v.abort_cycle, v.repulse, v.done_cyc);
    endtask

    initial begin
        vecs[0] = '{4'b1111, 1'b0, 1'b0, -1, 16, 6, 11};
        vecs[1] = '{4'b1001, 1'b1, 1'b0, -1, 24, 8, 16};
        vecs[2] = '{4'b0101, 1'b1, 1'b0, -1, 25, 9, 17};
        vecs[3] = '{4'b1111, 1'b1, 1'b0,  9, -1, 6, -1};
        vecs[4] = '{4'b1111, 1'b1, 1'b0, -1, 16, 6, 11};
        vecs[5] = '{4'b1111, 1'b1, 1'b1, -1, 16, 6, 11};

        s1.start = 1'b0; s1.abort = 1'b0; s1.out_ready = 1'b0;
        s2.start = 1'b0; s2.abort = 1'b0; s2.out_ready = 1'b0;
        mem2 = 32'hC0DE_5A17;
        for (int k = 0; k < 4; k++) mem[k] = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_dut1", 128'({s1.busy, s1.done, s1.out_valid, s1.out_last, s1.out_data, s1.mem_addr, s1.mem_rw}), 128'(0));
        check("reset_dut2", 128'({s2.busy, s2.done, s2.out_valid, s2.out_last, s2.out_data, s2.mem_addr, s2.mem_rw}), 128'(0));
        @(posedge clk); #1;
        rst_b = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // start together with abort in IDLE must not launch a stream
        @(posedge clk); #1;
        s1.start = 1'b1; s1.abort = 1'b1;
        @(posedge clk); #1;
        s1.start = 1'b0; s1.abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", 128'({s1.busy, s1.out_valid, s1.mem_addr}), 128'(0));
        $display("[TB] start+abort in IDLE: busy=%0d", s1.busy);

        // asynchronous reset in the middle of SEND
        @(posedge clk); #1;
        s1.start = 1'b1; s1.out_ready = 1'b1;
        @(posedge clk); #1;
        s1.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_reset_valid", 128'(s1.out_valid), 128'(1));
        #1 rst_b = 1'b1;
        #1;
        check("async_reset", 128'({s1.busy, s1.done, s1.out_valid, s1.out_last, s1.out_data, s1.mem_addr}), 128'(0));
        $display("[TB] async reset mid-SEND: out_valid=%0d busy=%0d", s1.out_valid, s1.busy);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
        s1.out_ready = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 128'({s1.busy, s1.done, s1.out_valid}), 128'(0));
        run_vec(6, vecs[0]);

        // single-word, single-beat instance
        @(posedge clk); #1;
        s2.start = 1'b1; s2.out_ready = 1'b1;
        for (int t = 0; t <= 6; t++) begin
            @(negedge clk);
            check("d1_ctrl", 128'({s2.out_valid, s2.out_last, s2.done, s2.busy, s2.mem_addr}),
                  128'({t == 3, t == 3, t == 4, (t >= 1 && t <= 4), 1'b0}));
            if (t == 3) begin
                check("d1_data", 128'(s2.out_data), 128'(mem2));
                $display("[TB] depth1 beat: data=%h last=%0d", s2.out_data, s2.out_last);
            end
            @(posedge clk); #1;
            s2.start = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
